ghash_h_powers_calc: RTL

Responder to the GHASH key-update sequencer. On a trigger pulse it captures the hash subkey H and computes H^1..H^N_H_POWERS sequentially in GF(2^128), one multiply per valid cycle. It stores all powers in a register bank and asserts a level ready flag when the whole set is consistent. The bank feeds the parallel N-lane GHASH datapath.

---
 rtl/ghash_h_powers_calc_pkg.sv | 24 ++
 rtl/ghash_h_powers_calc_if.sv | 42 ++++
 rtl/ghash_h_powers_calc_gf128_mult.sv | 34 +++
 rtl/ghash_h_powers_calc.sv | 101 ++++++++++
 4 files changed

// File: rtl/ghash_h_powers_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_h_powers_calc_pkg
//  Description : Shared GHASH constants, field reduction value and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ghash_h_powers_calc_pkg;

  localparam int GF_NB_DATA = 128;
  localparam int GHASH_N_H_POWERS_DEF = 8;
  localparam int GHASH_NB_STATE_DEF = 2;
  localparam int GHASH_NB_IDX_DEF = 3;

  // x^128 = 1 + x + x^2 + x^7 in the bit-reflected GCM ordering (MSB is x^0)
  localparam logic [GF_NB_DATA-1:0] GF128_R = {8'hE1, 120'h0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ghash_h_powers_calc_if.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_h_powers_calc_if
//  Description : Sequencer-side control and power-bank bus of the H-powers unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ghash_h_powers_calc_if #(
  parameter int N_H_POWERS = 8,
  parameter int NB_DATA    = 128,
  parameter int NB_STATE   = 2
);

  logic                             i_valid;
  logic                             i_trigger_h_powers_calc;
  logic [NB_DATA-1:0]               i_h_key;
  logic [N_H_POWERS*NB_DATA-1:0]    o_h_powers;
  logic                             o_h_powers_ready;
  logic                             o_busy;
  logic [NB_STATE-1:0]              o_state;

  modport master (
    output i_valid,
    output i_trigger_h_powers_calc,
    output i_h_key,
    input  o_h_powers,
    input  o_h_powers_ready,
    input  o_busy,
    input  o_state
  );

  modport slave (
    input  i_valid,
    input  i_trigger_h_powers_calc,
    input  i_h_key,
    output o_h_powers,
    output o_h_powers_ready,
    output o_busy,
    output o_state
  );

endinterface
`default_nettype wire

// File: rtl/ghash_h_powers_calc_gf128_mult.sv
`default_nettype none
// ============================================================================
//  Module      : gf128_mult
//  Description : Combinational GF(2^128) multiply in the GCM bit-reflected form.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf128_mult
  import ghash_h_powers_calc_pkg::*;
(
  input  wire logic [GF_NB_DATA-1:0] i_a,
  input  wire logic [GF_NB_DATA-1:0] i_b,
  output logic      [GF_NB_DATA-1:0] o_p
);

  logic [GF_NB_DATA-1:0] w_z [0:GF_NB_DATA];
  logic [GF_NB_DATA-1:0] w_v [0:GF_NB_DATA-1];

  assign w_z[0] = '0;
  assign w_v[0] = i_a;

  // Stage i consumes coefficient x^i of i_b, which sits at bit 127-i
  for (genvar i = 0; i < GF_NB_DATA; i++) begin : g_accum
    assign w_z[i+1] = i_b[GF_NB_DATA-1-i] ? (w_z[i] ^ w_v[i]) : w_z[i];
  end

  // Multiply-by-x is a right shift here; a bit falling off x^127 folds back via R
  for (genvar i = 0; i < GF_NB_DATA-1; i++) begin : g_shift
    assign w_v[i+1] = w_v[i][0] ? ((w_v[i] >> 1) ^ GF128_R) : (w_v[i] >> 1);
  end

  assign o_p = w_z[GF_NB_DATA];

endmodule
`default_nettype wire

// File: rtl/ghash_h_powers_calc.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_h_powers_calc
//  Description : Sequentially computes H^1..H^N into a bank for the GHASH lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ghash_h_powers_calc
  import ghash_h_powers_calc_pkg::*;
#(
  parameter int N_H_POWERS = GHASH_N_H_POWERS_DEF,
  parameter int NB_DATA    = GF_NB_DATA,
  parameter int NB_STATE   = GHASH_NB_STATE_DEF,
  parameter int NB_IDX     = GHASH_NB_IDX_DEF
) (
  input  wire logic              i_clock,
  input  wire logic              i_reset,
  ghash_h_powers_calc_if.slave   h_bus
);

  localparam logic [NB_IDX-1:0] C_IDX_ONE  = NB_IDX'(1);
  localparam logic [NB_IDX-1:0] C_IDX_LAST = NB_IDX'(N_H_POWERS-1);

  state_t                        r_state;
  state_t                        w_state_next;
  logic [NB_DATA-1:0]            r_h;
  logic [NB_DATA-1:0]            r_bank [0:N_H_POWERS-1];
  logic [NB_IDX-1:0]             r_idx;
  logic [NB_IDX-1:0]             w_prev_idx;
  logic [NB_DATA-1:0]            w_product;
  logic [N_H_POWERS*NB_DATA-1:0] w_h_powers;
  logic                          w_trigger;

  assign w_trigger  = h_bus.i_trigger_h_powers_calc;
  assign w_prev_idx = r_idx - C_IDX_ONE;

  gf128_mult u_gf128_mult (
    .i_a (r_bank[w_prev_idx]),
    .i_b (r_h),
    .o_p (w_product)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else if (h_bus.i_valid) begin
      r_state <= w_state_next;
    end
  end

  // A trigger wins in every state so a new H always restarts from scratch
  always_comb begin
    w_state_next = r_state;
    if (w_trigger) begin
      w_state_next = ST_CALC;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_CALC: begin
          if (r_idx == C_IDX_LAST) begin
            w_state_next = ST_DONE;
          end
        end
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_h   <= '0;
      r_idx <= '0;
      for (int k = 0; k < N_H_POWERS; k++) begin
        r_bank[k] <= '0;
      end
    end else if (h_bus.i_valid) begin
      if (w_trigger) begin
        r_h       <= h_bus.i_h_key;
        r_bank[0] <= h_bus.i_h_key;
        r_idx     <= C_IDX_ONE;
      end else if (r_state == ST_CALC) begin
        r_bank[r_idx] <= w_product;
        r_idx         <= r_idx + C_IDX_ONE;
      end
    end
  end

  always_comb begin
    w_h_powers = '0;
    for (int k = 0; k < N_H_POWERS; k++) begin
      w_h_powers[k*NB_DATA +: NB_DATA] = r_bank[k];
    end
  end

  assign h_bus.o_h_powers       = w_h_powers;
  assign h_bus.o_h_powers_ready = (r_state == ST_DONE);
  assign h_bus.o_busy           = (r_state == ST_CALC);
  assign h_bus.o_state          = NB_STATE'(r_state);

endmodule
`default_nettype wire
